// File: rtl/auth_initiator.sv
// Requester-side driver for the authentication responder: builds the request message from a
// host command, runs the req/ack handshake with timeout and retry, and checks the response header.
module auth_initiator #(
  parameter int unsigned MSG_LEN        = 256,
  parameter int unsigned HDR_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_type,
  input  logic [HDR_W-1:0]           cmd_param1,
  input  logic [HDR_W-1:0]           cmd_param2,
  input  logic [MSG_LEN-4*HDR_W-1:0] cmd_payload,
  output logic                       req_out,
  output logic [MSG_LEN-1:0]         auth_msg_req_out,
  output logic                       ack_out,
  input  logic                       resp_valid_in,
  input  logic [MSG_LEN-1:0]         auth_msg_resp_in,
  output logic                       done,
  output logic [2:0]                 status,
  output logic [4*HDR_W-1:0]         resp_header,
  output logic [MSG_LEN-4*HDR_W-1:0] resp_payload
);

  localparam int unsigned HdrW4 = 4 * HDR_W;
  localparam int unsigned PayW  = MSG_LEN - HdrW4;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CntW-1:0]  TmoLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]  GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0]  RetryMax = CntW'(MAX_RETRIES);
  localparam logic [HDR_W-1:0] Version  = HDR_W'(1);
  localparam logic [HDR_W-1:0] ErrType  = HDR_W'(8'h7F);
  localparam logic [HDR_W-1:0] TypeMask = HDR_W'(8'h7F);

  localparam logic [2:0] StatOk      = 3'd0;
  localparam logic [2:0] StatErrResp = 3'd1;
  localparam logic [2:0] StatBadVer  = 3'd2;
  localparam logic [2:0] StatBadType = 3'd3;
  localparam logic [2:0] StatTimeout = 3'd4;
  localparam logic [2:0] StatBadCmd  = 3'd5;

  typedef enum logic [2:0] {
    StIdle, StSend, StWaitResp, StCheck, StAck, StGap, StFinish
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CntW-1:0]    retry_q, retry_d;
  logic [HDR_W-1:0]   code_q, code_d;
  logic [HDR_W-1:0]   p1_q, p1_d;
  logic [HDR_W-1:0]   p2_q, p2_d;
  logic [PayW-1:0]    pay_q, pay_d;
  logic [MSG_LEN-1:0] msg_q, msg_d;
  logic               req_q, req_d;
  logic               ack_q, ack_d;
  logic               done_q, done_d;
  logic [2:0]         status_q, status_d;
  logic [2:0]         pend_q, pend_d;
  logic [HdrW4-1:0]   hdr_q, hdr_d;
  logic [PayW-1:0]    rpay_q, rpay_d;

  logic [HDR_W-1:0]   rsp_ver, rsp_type;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + CntW'(1);
  endfunction

  assign rsp_ver  = hdr_q[HdrW4-1 -: HDR_W];
  assign rsp_type = hdr_q[HdrW4-HDR_W-1 -: HDR_W];

  // Next-state and datapath updates for the command/handshake sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    code_d   = code_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    pay_d    = pay_q;
    msg_d    = msg_q;
    req_d    = req_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    status_d = status_q;
    pend_d   = pend_q;
    hdr_d    = hdr_q;
    rpay_d   = rpay_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          p1_d    = cmd_param1;
          p2_d    = cmd_param2;
          pay_d   = cmd_payload;
          cnt_d   = '0;
          retry_d = '0;
          case (cmd_type)
            2'd0:    code_d = HDR_W'(8'h81);
            2'd1:    code_d = HDR_W'(8'h82);
            2'd2:    code_d = HDR_W'(8'h83);
            default: code_d = '0;
          endcase
          if (cmd_type == 2'd3) begin
            status_d = StatBadCmd;
            state_d  = StFinish;
          end else begin
            state_d  = StSend;
          end
        end
      end

      // Re-entered from GAP on retry; the captured fields rebuild the identical message.
      StSend: begin
        msg_d   = {Version, code_q, p1_q, p2_q, pay_q};
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = StWaitResp;
      end

      // A response on the expiry cycle takes priority over the timeout.
      StWaitResp: begin
        if (resp_valid_in) begin
          hdr_d   = auth_msg_resp_in[MSG_LEN-1 -: HdrW4];
          rpay_d  = auth_msg_resp_in[PayW-1:0];
          req_d   = 1'b0;
          state_d = StCheck;
        end else if (cnt_q == TmoLast) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (retry_q < RetryMax) begin
            retry_d = sat_inc(retry_q);
            state_d = StGap;
          end else begin
            status_d = StatTimeout;
            state_d  = StFinish;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      StCheck: begin
        if (rsp_ver != Version) begin
          pend_d = StatBadVer;
        end else if (rsp_type == ErrType) begin
          pend_d = StatErrResp;
        end else if (rsp_type != (code_q & TypeMask)) begin
          pend_d = StatBadType;
        end else begin
          pend_d = StatOk;
        end
        ack_d   = 1'b1;
        cnt_d   = '0;
        state_d = StAck;
      end

      // Responder must drop its valid in answer to ack; a stuck valid ends as a timeout.
      StAck: begin
        if (!resp_valid_in) begin
          ack_d    = 1'b0;
          status_d = pend_q;
          state_d  = StFinish;
        end else if (cnt_q == TmoLast) begin
          ack_d    = 1'b0;
          status_d = StatTimeout;
          state_d  = StFinish;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StSend;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      retry_q  <= '0;
      code_q   <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      pay_q    <= '0;
      msg_q    <= '0;
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      status_q <= StatOk;
      pend_q   <= StatOk;
      hdr_q    <= '0;
      rpay_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      code_q   <= code_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      pay_q    <= pay_d;
      msg_q    <= msg_d;
      req_q    <= req_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      status_q <= status_d;
      pend_q   <= pend_d;
      hdr_q    <= hdr_d;
      rpay_q   <= rpay_d;
    end
  end

  assign cmd_ready        = (state_q == StIdle);
  assign req_out          = req_q;
  assign auth_msg_req_out = msg_q;
  assign ack_out          = ack_q;
  assign done             = done_q;
  assign status           = status_q;
  assign resp_header      = hdr_q;
  assign resp_payload     = rpay_q;

endmodule

// File: tb/tb_auth_initiator.sv
// Directed bench for auth_initiator: the bench plays the host and the responder, pushes the
// expected outcome of each command onto a scoreboard and compares when done pulses.
module tb_auth_initiator;

  localparam int unsigned MsgLen = 256;
  localparam int unsigned HdrW   = 8;
  localparam int unsigned PayW   = MsgLen - 4 * HdrW;
  localparam int unsigned Tmo    = 64;
  localparam int unsigned Gap    = 2;

  // Responder behaviour per command.
  localparam int ModeNormal  = 0;
  localparam int ModeSilent  = 1;
  localparam int ModeStuck   = 2;
  localparam int ModeIllegal = 3;

  typedef struct packed {
    logic [2:0]      status;
    logic [31:0]     hdr;
    logic [PayW-1:0] pay;
    logic            has_resp;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [HdrW-1:0]   cmd_param1;
  logic [HdrW-1:0]   cmd_param2;
  logic [PayW-1:0]   cmd_payload;
  logic              req_out;
  logic [MsgLen-1:0] auth_msg_req_out;
  logic              ack_out;
  logic              resp_valid_in;
  logic [MsgLen-1:0] auth_msg_resp_in;
  logic              done;
  logic [2:0]        status;
  logic [4*HdrW-1:0] resp_header;
  logic [PayW-1:0]   resp_payload;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  auth_initiator #(
    .MSG_LEN        (MsgLen),
    .HDR_W          (HdrW),
    .TIMEOUT_CYCLES (Tmo),
    .MAX_RETRIES    (2),
    .GAP_CYCLES     (Gap)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_type         (cmd_type),
    .cmd_param1       (cmd_param1),
    .cmd_param2       (cmd_param2),
    .cmd_payload      (cmd_payload),
    .req_out          (req_out),
    .auth_msg_req_out (auth_msg_req_out),
    .ack_out          (ack_out),
    .resp_valid_in    (resp_valid_in),
    .auth_msg_resp_in (auth_msg_resp_in),
    .done             (done),
    .status           (status),
    .resp_header      (resp_header),
    .resp_payload     (resp_payload)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PayW-1:0] rand_pay();
    logic [PayW-1:0] p;
    for (int i = 0; i < PayW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // Issue one command and act as the responder; delay counts cycles after req_out is first seen.
  task automatic run_cmd(input logic [1:0] ty, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [PayW-1:0] pay, input int mode, input int delay,
                         input logic [31:0] rhdr, input logic [PayW-1:0] rpay,
                         input logic [2:0] exp_st);
    exp_t e;
    int   n;
    int   w;
    logic rose;
    logic [7:0] code;
    e.status   = exp_st;
    e.hdr      = rhdr;
    e.pay      = rpay;
    e.has_resp = (mode == ModeNormal) || (mode == ModeStuck);
    sb.push_back(e);

    @(negedge clk);
    check("cmd_ready_idle", {255'd0, cmd_ready}, 256'd1);
    cmd_valid   = 1'b1;
    cmd_type    = ty;
    cmd_param1  = p1;
    cmd_param2  = p2;
    cmd_payload = pay;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;

    if (mode == ModeIllegal) begin
      rose = 1'b0;
      while (done !== 1'b1 && n < 10) begin
        if (req_out) rose = 1'b1;
        @(negedge clk);
        n++;
      end
      check("illegal_done_latency", 256'(n), 256'd2);
      check("illegal_no_req", {255'd0, rose | req_out}, 256'd0);
    end else begin
      while (req_out !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("req_latency", 256'(n), 256'd2);
      code = 8'h81 + {6'd0, ty};
      check("req_header", 256'(auth_msg_req_out[MsgLen-1 -: 32]), 256'({8'h01, code, p1, p2}));
      check("req_payload", 256'(auth_msg_req_out[PayW-1:0]), 256'(pay));
      check("cmd_ready_busy", {255'd0, cmd_ready}, 256'd0);

      if (mode == ModeSilent) begin
        int   bursts;
        int   hi_len;
        int   lo_len;
        int   span;
        logic prev;
        bursts = 1;
        hi_len = 1;
        lo_len = 0;
        span   = 0;
        prev   = 1'b1;
        while (done !== 1'b1 && span < 400) begin
          @(negedge clk);
          span++;
          if (req_out) begin
            if (!prev) begin
              bursts++;
              // GAP cycles plus the SEND cycle that re-registers req_out.
              check("retry_gap_len", 256'(lo_len), 256'(Gap + 1));
              lo_len = 0;
            end
            hi_len++;
          end else begin
            if (prev) begin
              check("burst_len", 256'(hi_len), 256'(Tmo));
              hi_len = 0;
            end
            lo_len++;
          end
          prev = req_out;
        end
        check("burst_count", 256'(bursts), 256'd3);
        check("timeout_span", 256'(span), 256'(3 * (1 + Tmo) + 2 * Gap));
      end else begin
        repeat (delay) @(negedge clk);
        resp_valid_in    = 1'b1;
        auth_msg_resp_in = {rhdr, rpay};
        @(negedge clk);
        check("req_drop_on_resp", {255'd0, req_out}, 256'd0);
        w = 0;
        while (ack_out !== 1'b1 && w < 8) begin
          @(negedge clk);
          w++;
        end
        check("ack_seen", {255'd0, ack_out}, 256'd1);
        if (mode == ModeNormal) resp_valid_in = 1'b0;
      end
    end

    w = 0;
    while (done !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", {255'd0, done}, 256'd1);
    check("ack_low_at_done", {255'd0, ack_out}, 256'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("status", 256'(status), 256'(e.status));
      if (e.has_resp) begin
        check("resp_header", 256'(resp_header), 256'(e.hdr));
        check("resp_payload", 256'(resp_payload), 256'(e.pay));
      end
    end
    resp_valid_in = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {255'd0, done}, 256'd0);
    check("status_held", 256'(status), 256'(e.status));
  endtask

  initial begin
    logic [PayW-1:0] nonce;
    logic [PayW-1:0] rp;
    reset            = 1'b1;
    cmd_valid        = 1'b0;
    cmd_type         = 2'd0;
    cmd_param1       = '0;
    cmd_param2       = '0;
    cmd_payload      = '0;
    resp_valid_in    = 1'b0;
    auth_msg_resp_in = '0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {255'd0, cmd_ready}, 256'd1);
    check("rst_req", {255'd0, req_out}, 256'd0);
    check("rst_ack", {255'd0, ack_out}, 256'd0);
    check("rst_done", {255'd0, done}, 256'd0);
    check("rst_status", 256'(status), 256'd0);
    check("rst_req_msg", auth_msg_req_out, 256'd0);
    check("rst_hdr", 256'(resp_header), 256'd0);
    check("rst_pay", 256'(resp_payload), 256'd0);
    reset = 1'b0;

    // GET_DIGESTS with a clean response.
    rp = rand_pay();
    run_cmd(2'd0, 8'h00, 8'h00, '0, ModeNormal, 3, 32'h01010000, rp, 3'd0);

    // CHALLENGE carrying a nonce; response payload must come back verbatim.
    nonce = rand_pay();
    rp    = rand_pay();
    run_cmd(2'd2, 8'h03, 8'h00, nonce, ModeNormal, 5, 32'h01030000, rp, 3'd0);

    // Error response; error code sits in Param1.
    run_cmd(2'd1, 8'h00, 8'h00, '0, ModeNormal, 2, 32'h017F0500, '0, 3'd1);
    check("err_code_param1", 256'(resp_header[15:8]), 256'h05);

    // Illegal command never touches the responder.
    run_cmd(2'd3, 8'h11, 8'h22, '0, ModeIllegal, 0, '0, '0, 3'd5);

    // Bad version outranks the error-type check.
    run_cmd(2'd0, 8'h00, 8'h00, '0, ModeNormal, 1, 32'h027F0000, '0, 3'd2);

    // Reset in the middle of WAIT_RESP; status from the previous command must clear too.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_req", {255'd0, req_out}, 256'd1);
    reset = 1'b1;
    #1;
    check("async_rst_req", {255'd0, req_out}, 256'd0);
    check("async_rst_msg", auth_msg_req_out, 256'd0);
    check("async_rst_status", 256'(status), 256'd0);
    check("async_rst_hdr", 256'(resp_header), 256'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {255'd0, cmd_ready}, 256'd1);
    check("post_rst_req", {255'd0, req_out}, 256'd0);

    // Type mismatch against the request code.
    run_cmd(2'd0, 8'h00, 8'h00, '0, ModeNormal, 4, 32'h01020000, '0, 3'd3);

    // Response lands on the last WAIT_RESP cycle and must beat the timeout.
    rp = rand_pay();
    run_cmd(2'd1, 8'h01, 8'h02, '0, ModeNormal, Tmo - 1, 32'h01020102, rp, 3'd0);

    // No response at all: three bursts then TIMEOUT.
    run_cmd(2'd0, 8'h00, 8'h00, '0, ModeSilent, 0, '0, '0, 3'd4);

    // Responder never releases its valid during ACK: CHECK result replaced by TIMEOUT.
    run_cmd(2'd2, 8'h00, 8'h00, nonce, ModeStuck, 2, 32'h01030000, '0, 3'd4);

    check("scoreboard_empty", 256'(sb.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
